// File: rtl/sram_axi_bridge.sv
// Bridge from the data cache's SRAM-like req/addr_ok/data_ok port to AXI3 single-beat reads and writes.
// Optional sticky AXI error flag `resp_err` is built when SRAM_AXI_RESP_ERR_EN is defined.
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // SRAM-like side
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // FSM state for checkers
  output logic [2:0]  state_dbg
`ifdef SRAM_AXI_RESP_ERR_EN
  ,
  output logic        resp_err
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WREQ  = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        aw_done;
  logic        w_done;
  logic        ar_hs;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic [1:0]  eff_size;

  // Handshake rule on every channel: a transfer happens in a cycle where
  // valid and ready are both high; valid never waits on ready.
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid  & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bvalid  & bready;

  assign addr_ok = req & (state == S_IDLE) & ~rst;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (addr_ok) state_nxt = wr ? S_WREQ : S_RADDR;
      S_RADDR: if (ar_hs) state_nxt = S_RDATA;
      S_RDATA: if (r_hs) state_nxt = S_DONE;
      S_WREQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = S_WRESP;
      S_WRESP: if (b_hs) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (addr_ok) begin
        lat_size  <= size;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
      // Flags only live inside WREQ; they are cleared as the FSM leaves it.
      if (state == S_WREQ && state_nxt != S_WREQ) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_hs) rdata <= rdata_axi;
    end
  end

  // Size 3 is treated as a word access everywhere.
  assign eff_size = (lat_size == 2'd3) ? 2'd2 : lat_size;

  always_comb begin
    case (eff_size)
      2'd0:    wstrb = 4'b0001 << lat_addr[1:0];
      2'd1:    wstrb = 4'b0011 << {lat_addr[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

  assign arid      = AXI_ID;
  assign araddr    = lat_addr;
  assign arlen     = 8'd0;
  assign arsize    = {1'b0, eff_size};
  assign arburst   = 2'b01;
  assign arvalid   = (state == S_RADDR);
  assign rready    = (state == S_RDATA);

  assign awid      = AXI_ID;
  assign awaddr    = lat_addr;
  assign awlen     = 8'd0;
  assign awsize    = {1'b0, eff_size};
  assign awburst   = 2'b01;
  assign awvalid   = (state == S_WREQ) & ~aw_done;

  assign wid       = AXI_ID;
  assign wdata_axi = lat_wdata;
  assign wlast     = 1'b1;
  assign wvalid    = (state == S_WREQ) & ~w_done;

  assign bready    = (state == S_WRESP);
  assign data_ok   = (state == S_DONE);
  assign state_dbg = state;

  // IDs and rlast carry no information for single-beat, single-ID traffic.
  logic unused_axi_in;
  assign unused_axi_in = ^{rid, rlast, bid};

`ifdef SRAM_AXI_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if ((r_hs && rresp != 2'b00) || (b_hs && bresp != 2'b00)) begin
      resp_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed test-plan steps plus random transactions against a
// handshake-event model of the protocol; resp_err checks are built with SRAM_AXI_RESP_ERR_EN.
`timescale 1ns/1ps
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata_axi, rdata_axi;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, state_dbg;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
`ifdef SRAM_AXI_RESP_ERR_EN
  logic        resp_err;
`endif

  int comp_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;
  logic        err_model = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .state_dbg(state_dbg)
`ifdef SRAM_AXI_RESP_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0;
    rdata_axi = 32'd0; rresp = 2'd0; bresp = 2'd0;
    rid = 4'd1; bid = 4'd1; rlast = 1'b1;
  endtask

  // Drives one request and plays the AXI slave with per-channel wait counts.
  // Expected behaviour is derived only from which handshakes have happened so far.
  task automatic run_txn(input logic t_wr, input logic [1:0] t_size, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input logic [31:0] t_rd,
                         input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w,
                         input logic [1:0] t_resp, output int done_cyc);
    int ar_c, r_c, aw_c, w_c, b_c;
    bit ar_s, r_s, aw_s, w_s, b_s, fin;
    logic [2:0] exp_sz;
    logic [3:0] exp_strb;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    ar_s = 0; r_s = 0; aw_s = 0; w_s = 0; b_s = 0; fin = 0;
    done_cyc = -1;
    exp_sz = (t_size == 2'd3) ? 3'd2 : {1'b0, t_size};
    if (exp_sz == 3'd0)      exp_strb = 4'(1 << (t_addr % 4));
    else if (exp_sz == 3'd1) exp_strb = (t_addr % 4 >= 2) ? 4'b1100 : 4'b0011;
    else                     exp_strb = 4'b1111;
    if (!t_wr) last_rd = t_rd;
    exp_q.push_back(last_rd);

    @(negedge clk);
    slave_idle();
    req = 1'b1; wr = t_wr; size = t_size; addr = t_addr; wdata = t_wdata;
    #1;
    check("addr_ok_accept", addr_ok, 1'b1);
    check("data_ok_idle", data_ok, 1'b0);

    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      // request inputs are garbage after acceptance; the bridge must use its latched copy
      req = 1'($urandom_range(0, 1)); wr = 1'($urandom); size = 2'($urandom);
      addr = $urandom; wdata = $urandom;
      arready = arvalid && (ar_c >= ar_w);
      awready = awvalid && (aw_c >= aw_w);
      wready  = wvalid && (w_c >= w_w);
      rvalid  = ar_s && !r_s && (r_c >= r_w);
      bvalid  = aw_s && w_s && !b_s && (b_c >= b_w);
      rdata_axi = rvalid ? t_rd : $urandom;
      rresp = rvalid ? t_resp : 2'($urandom);
      bresp = bvalid ? t_resp : 2'($urandom);
      #1;
      check("addr_ok_busy", addr_ok, 1'b0);
      check("arvalid", arvalid, !t_wr && !ar_s);
      check("rready", rready, !t_wr && ar_s && !r_s);
      check("awvalid", awvalid, t_wr && !aw_s);
      check("wvalid", wvalid, t_wr && !w_s);
      check("bready", bready, t_wr && aw_s && w_s && !b_s);
      check("data_ok", data_ok, r_s || b_s);
      if (!t_wr && !ar_s) begin
        check("araddr", araddr, t_addr);
        check("arsize", arsize, exp_sz);
        check("arlen", arlen, 8'd0);
        check("arburst", arburst, 2'b01);
        check("arid", arid, 4'd1);
      end
      if (t_wr && !aw_s) begin
        check("awaddr", awaddr, t_addr);
        check("awsize", awsize, exp_sz);
        check("awlen", awlen, 8'd0);
        check("awburst", awburst, 2'b01);
        check("awid", awid, 4'd1);
      end
      if (t_wr && !w_s) begin
        check("wdata_axi", wdata_axi, t_wdata);
        check("wstrb", wstrb, exp_strb);
        check("wlast", wlast, 1'b1);
        check("wid", wid, 4'd1);
      end
      if (r_s || b_s) begin
        fin = 1;
        done_cyc = cyc;
        check("rdata", rdata, exp_q.pop_front());
`ifdef SRAM_AXI_RESP_ERR_EN
        check("resp_err", resp_err, err_model);
`endif
      end else begin
        if (rvalid && rready) begin r_s = 1; err_model |= (t_resp != 2'd0); end
        else if (ar_s) r_c++;
        if (bvalid && bready) begin b_s = 1; err_model |= (t_resp != 2'd0); end
        else if (aw_s && w_s) b_c++;
        if (arvalid && arready) ar_s = 1; else if (arvalid) ar_c++;
        if (awvalid && awready) aw_s = 1; else if (awvalid) aw_c++;
        if (wvalid && wready) w_s = 1; else if (wvalid) w_c++;
      end
    end
    check("txn_completed", fin, 1'b1);
    if (!fin) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    slave_idle();
    rst = 1'b1; req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("addr_ok_in_rst", addr_ok, 1'b0);
    end
    rst = 1'b0; req = 1'b0;
    last_rd = 32'd0; err_model = 1'b0;
  endtask

  initial begin : main
    int lat;
    int n_aok;
    bit r_pend;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    slave_idle();

    // reset values
    do_reset();
    @(negedge clk);
    #1;
    check("rst_addr_ok", addr_ok, 1'b0);
    check("rst_data_ok", data_ok, 1'b0);
    check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    check("rst_readies", {rready, bready}, 2'b00);
    check("rst_rdata", rdata, 32'd0);
`ifdef SRAM_AXI_RESP_ERR_EN
    check("rst_resp_err", resp_err, 1'b0);
`endif

    // zero-wait word read
    run_txn(1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'd0, lat);
    check("read_latency", lat, 3);

    // zero-wait byte write to the top lane
    run_txn(1'b1, 2'd0, 32'h8000_0003, 32'h5A00_0000, 32'h0, 0, 0, 0, 0, 0, 2'd0, lat);
    check("write_latency", lat, 3);

    // W channel stalled three cycles behind AW
    run_txn(1'b1, 2'd1, 32'h0000_1002, 32'h1234_5678, 32'h0, 0, 0, 0, 3, 0, 2'd0, lat);
    check("write_wstall_latency", lat, 6);

    // req held high over three back-to-back zero-wait reads
    n_aok = 0;
    r_pend = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0100; wdata = 32'd0;
      arready = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rvalid = r_pend; rdata_axi = $urandom; rresp = 2'd0;
      #1;
      check("b2b_addr_ok", addr_ok, (c % 4) == 0);
      check("b2b_data_ok", data_ok, (c % 4) == 3);
      if (addr_ok) n_aok++;
      if (data_ok) check("b2b_rdata", rdata, exp_q.pop_front());
      if (rvalid && rready) begin exp_q.push_back(rdata_axi); last_rd = rdata_axi; r_pend = 0; end
      if (arvalid && arready) r_pend = 1;
    end
    check("b2b_accept_count", n_aok, 3);
    check("b2b_queue_drained", exp_q.size(), 0);

    // reset while waiting in the read data phase
    @(negedge clk);
    slave_idle();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_2000;
    #1;
    check("mid_rst_accept", addr_ok, 1'b1);
    @(negedge clk);
    req = 1'b0; arready = 1'b1;
    #1;
    check("mid_rst_arvalid", arvalid, 1'b1);
    @(negedge clk);
    arready = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_rready", rready, 1'b1);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    check("mid_rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    check("mid_rst_readies", {rready, bready}, 2'b00);
    check("mid_rst_rdata", rdata, 32'd0);
    last_rd = 32'd0; err_model = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("mid_rst_no_data_ok", data_ok, 1'b0);
    end
    run_txn(1'b0, 2'd3, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 2'd0, lat);
    check("post_rst_read_latency", lat, 3);

    // error response on B, then OKAY traffic: sticky flag where built, ignored otherwise
    run_txn(1'b1, 2'd2, 32'h0000_3000, 32'hA5A5_A5A5, 32'h0, 0, 0, 0, 0, 0, 2'b10, lat);
    run_txn(1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h0BAD_0BAD, 1, 1, 0, 0, 0, 2'b00, lat);
    run_txn(1'b1, 2'd0, 32'h0000_3001, 32'h0000_7700, 32'h0, 0, 0, 0, 0, 1, 2'b00, lat);
`ifdef SRAM_AXI_RESP_ERR_EN
    check("resp_err_sticky", resp_err, 1'b1);
    do_reset();
    @(negedge clk);
    #1;
    check("resp_err_cleared", resp_err, 1'b0);
`endif

    // random traffic
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)), lat);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $finish;
  end

endmodule
